atari7800_video_out: RTL and testbench



---
 rtl/atari7800_video_out.sv | 154 +++++++++++++++
 tb/tb_atari7800_video_out.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/atari7800_video_out.sv
// atari7800_video_out: Maria pixel output stage.
// Palette lookup, flag delay, line/frame measurement.
module atari7800_video_out #(
  parameter DEF_PAL_HEX = "ntsc.hex"
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_in,
  input  logic [7:0]  yc,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblank_in,
  input  logic        vblank_in,
  input  logic        pal_wr,
  input  logic [7:0]  pal_addr,
  input  logic [23:0] pal_data,
  output logic        ce_pix,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank,
  output logic [8:0]  line_width,
  output logic [8:0]  line_count,
  output logic        pal_detect
);

  // flag bundles are {hsync, vsync, hblank, vblank}
  localparam int HS = 3;
  localparam int VS = 2;
  localparam int HB = 1;
  localparam int VB = 0;

  localparam logic [8:0] SAT = 9'd511;
  localparam logic [8:0] PAL_MIN = 9'd287;

  logic [23:0] pal_mem [256];

  logic [7:0]  s0_yc_q;
  logic [3:0]  s0_fl_q;
  logic [3:0]  pv_fl_q;
  logic [3:0]  s1_fl_q;
  logic [3:0]  s2_fl_q;
  logic [23:0] rd_q;
  logic [23:0] rgb_q;
  logic        ce_pix_q;

  logic [8:0]  wcnt_q, wcnt_d;
  logic [8:0]  lw_q, lw_d;
  logic [8:0]  lcnt_q, lcnt_d;
  logic [8:0]  lc_q, lc_d;
  logic        pd_q, pd_d;

  logic        hb_rise;
  logic        hs_rise;
  logic        vs_rise;
  logic [8:0]  wcnt_inc;
  logic [8:0]  lcnt_inc;

  // palette write port, independent of the pixel strobe
  always_ff @(posedge clk_sys) begin
    if (pal_wr) pal_mem[pal_addr] <= pal_data;
  end

  // three-stage pixel pipeline advancing on ce_in
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s0_yc_q  <= '0;
      s0_fl_q  <= '0;
      pv_fl_q  <= '0;
      s1_fl_q  <= '0;
      s2_fl_q  <= '0;
      rd_q     <= '0;
      rgb_q    <= '0;
      ce_pix_q <= 1'b0;
    end else begin
      ce_pix_q <= ce_in;
      if (ce_in) begin
        s0_yc_q <= yc;
        s0_fl_q <= {hsync_in, vsync_in,
                    hblank_in, vblank_in};
        pv_fl_q <= s0_fl_q;
        s1_fl_q <= s0_fl_q;
        rd_q    <= pal_mem[s0_yc_q];
        s2_fl_q <= s1_fl_q;
        rgb_q   <= (s1_fl_q[HB] | s1_fl_q[VB])
                   ? 24'h0 : rd_q;
      end
    end
  end

  // edge detect on the freshly captured S0 sample
  always_comb begin
    hb_rise  = s0_fl_q[HB] & ~pv_fl_q[HB];
    hs_rise  = s0_fl_q[HS] & ~pv_fl_q[HS];
    vs_rise  = s0_fl_q[VS] & ~pv_fl_q[VS];
    wcnt_inc = (wcnt_q == SAT) ? SAT
                               : wcnt_q + 9'd1;
    lcnt_inc = (lcnt_q == SAT) ? SAT
                               : lcnt_q + 9'd1;
    wcnt_d = wcnt_q;
    lw_d   = lw_q;
    lcnt_d = lcnt_q;
    lc_d   = lc_q;
    pd_d   = pd_q;
    if (ce_pix_q) begin
      if (hb_rise) begin
        lw_d   = wcnt_q;
        wcnt_d = '0;
      end else if (!s0_fl_q[HB]) begin
        wcnt_d = wcnt_inc;
      end
      if (vs_rise) begin
        lc_d   = hs_rise ? lcnt_inc : lcnt_q;
        pd_d   = (lc_d > PAL_MIN);
        lcnt_d = '0;
      end else if (hs_rise) begin
        lcnt_d = lcnt_inc;
      end
    end
  end

  // measurement registers, one clock behind the strobe
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wcnt_q <= '0;
      lw_q   <= '0;
      lcnt_q <= '0;
      lc_q   <= '0;
      pd_q   <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      lw_q   <= lw_d;
      lcnt_q <= lcnt_d;
      lc_q   <= lc_d;
      pd_q   <= pd_d;
    end
  end

  assign ce_pix     = ce_pix_q;
  assign r          = rgb_q[23:16];
  assign g          = rgb_q[15:8];
  assign b          = rgb_q[7:0];
  assign hsync      = s2_fl_q[HS];
  assign vsync      = s2_fl_q[VS];
  assign hblank     = s2_fl_q[HB];
  assign vblank     = s2_fl_q[VB];
  assign line_width = lw_q;
  assign line_count = lc_q;
  assign pal_detect = pd_q;

endmodule

// File: tb/tb_atari7800_video_out.sv
// tb_atari7800_video_out: directed + random bench
// against a sample-level reference model.
module tb_atari7800_video_out;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ce_in;
  logic [7:0]  yc;
  logic        hsync_in, vsync_in;
  logic        hblank_in, vblank_in;
  logic        pal_wr;
  logic [7:0]  pal_addr;
  logic [23:0] pal_data;
  logic        ce_pix;
  logic [7:0]  r, g, b;
  logic        hsync, vsync, hblank, vblank;
  logic [8:0]  line_width, line_count;
  logic        pal_detect;

  int checks = 0;
  int failures = 0;

  always #5 clk_sys = ~clk_sys;

  atari7800_video_out dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ce_in      (ce_in),
    .yc         (yc),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblank_in  (hblank_in),
    .vblank_in  (vblank_in),
    .pal_wr     (pal_wr),
    .pal_addr   (pal_addr),
    .pal_data   (pal_data),
    .ce_pix     (ce_pix),
    .r          (r),
    .g          (g),
    .b          (b),
    .hsync      (hsync),
    .vsync      (vsync),
    .hblank     (hblank),
    .vblank     (vblank),
    .line_width (line_width),
    .line_count (line_count),
    .pal_detect (pal_detect)
  );

  // reference model: palette image and per-sample history
  logic [23:0] pm [256];
  logic [7:0]  pend_yc;
  logic [3:0]  pend_fl;
  logic [23:0] res_rgb;
  logic [3:0]  res_fl;
  logic [23:0] exp_rgb;
  logic [3:0]  exp_fl;
  logic [8:0]  exp_lw, exp_lc;
  logic        exp_pd;
  int          m_wc, m_lc;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    pend_yc = '0; pend_fl = '0;
    res_rgb = '0; res_fl = '0;
    exp_rgb = '0; exp_fl = '0;
    exp_lw = '0; exp_lc = '0; exp_pd = 1'b0;
    m_wc = 0; m_lc = 0;
  endtask

  function automatic logic [7:0] rnd8();
    return 8'($urandom);
  endfunction

  task automatic pal_write(input logic [7:0] a,
                           input logic [23:0] d);
    @(negedge clk_sys);
    pal_wr = 1'b1; pal_addr = a; pal_data = d;
    pm[a] = d;
    @(posedge clk_sys); #1;
    pal_wr = 1'b0;
  endtask

  // one pixel strobe followed by one idle clock
  task automatic strobe_w(input logic [7:0] y,
                          input logic [3:0] f,
                          input logic w,
                          input logic [7:0] wa,
                          input logic [23:0] wd);
    int t;
    @(negedge clk_sys);
    ce_in = 1'b1; yc = y;
    {hsync_in, vsync_in, hblank_in, vblank_in} = f;
    pal_wr = w; pal_addr = wa; pal_data = wd;
    // output now shows sample two strobes back
    exp_rgb = res_rgb; exp_fl = res_fl;
    // previous sample looks up the palette now
    res_rgb = (pend_fl[1] | pend_fl[0])
              ? 24'h0 : pm[pend_yc];
    res_fl = pend_fl;
    // active width between hblank rises
    if (f[1] && !pend_fl[1]) begin
      exp_lw = 9'(m_wc); m_wc = 0;
    end else if (!f[1]) begin
      m_wc = (m_wc < 511) ? m_wc + 1 : 511;
    end
    // hsync rises between vsync rises
    if (f[2] && !pend_fl[2]) begin
      t = m_lc + ((f[3] && !pend_fl[3]) ? 1 : 0);
      if (t > 511) t = 511;
      exp_lc = 9'(t); exp_pd = (t > 287);
      m_lc = 0;
    end else if (f[3] && !pend_fl[3]) begin
      m_lc = (m_lc < 511) ? m_lc + 1 : 511;
    end
    pend_yc = y; pend_fl = f;
    if (w) pm[wa] = wd;
    @(posedge clk_sys); #1;
    chk("ce_pix_hi", 32'(ce_pix), 32'd1);
    ce_in = 1'b0; pal_wr = 1'b0;
    @(posedge clk_sys); #1;
    chk("ce_pix_lo", 32'(ce_pix), 32'd0);
    chk("rgb", 32'({r, g, b}), 32'(exp_rgb));
    chk("flags", 32'({hsync, vsync, hblank, vblank}),
        32'(exp_fl));
    chk("meas",
        32'({line_width, line_count, pal_detect}),
        32'({exp_lw, exp_lc, exp_pd}));
  endtask

  task automatic strobe(input logic [7:0] y,
                        input logic [3:0] f);
    strobe_w(y, f, 1'b0, 8'h0, 24'h0);
  endtask

  task automatic frame(input int nl, input bit co);
    for (int i = 0; i < nl; i++) begin
      strobe(rnd8(), 4'b1000);
      strobe(rnd8(), 4'b0000);
    end
    strobe(rnd8(), co ? 4'b1100 : 4'b0100);
    strobe(rnd8(), 4'b0000);
  endtask

  initial begin
    reset = 1'b1; ce_in = 1'b0; yc = '0;
    hsync_in = 0; vsync_in = 0;
    hblank_in = 0; vblank_in = 0;
    pal_wr = 0; pal_addr = '0; pal_data = '0;
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset_out",
        32'({r, g, b, hsync, vsync, hblank,
             vblank, ce_pix}), 32'd0);
    chk("reset_meas",
        32'({line_width, line_count, pal_detect}),
        32'd0);
    @(negedge clk_sys);
    reset = 1'b0;

    for (int i = 0; i < 256; i++)
      pal_write(8'(i), 24'($urandom));
    pal_write(8'h1F, 24'h123456);
    pal_write(8'h40, 24'h111111);

    // basic lookup, two-strobe latency
    strobe(8'h1F, 4'b0000);
    strobe(rnd8(), 4'b0000);
    strobe(rnd8(), 4'b0000);
    chk("rgb_1F", 32'({r, g, b}), 32'h123456);

    // blanked pixel is forced black
    strobe(8'hFF, 4'b0010);
    strobe(rnd8(), 4'b0000);
    chk("hb_early", 32'(hblank), 32'd0);
    strobe(rnd8(), 4'b0000);
    chk("hb_late", 32'(hblank), 32'd1);
    chk("hb_black", 32'({r, g, b}), 32'd0);

    // write collides with S1 read: old data first
    strobe(8'h40, 4'b0000);
    strobe_w(8'h40, 4'b0000, 1'b1, 8'h40, 24'hABCDEF);
    strobe(rnd8(), 4'b0000);
    chk("wr_old", 32'({r, g, b}), 32'h111111);
    strobe(rnd8(), 4'b0000);
    chk("wr_new", 32'({r, g, b}), 32'hABCDEF);

    // random pixels and flags
    repeat (200) begin
      strobe(rnd8(),
             {($urandom % 8) == 0, ($urandom % 16) == 0,
              ($urandom % 4) == 0, ($urandom % 8) == 0});
    end

    // line width, nominal and saturated
    repeat (3) strobe(rnd8(), 4'b0010);
    repeat (320) strobe(rnd8(), 4'b0000);
    strobe(rnd8(), 4'b0010);
    chk("lw_320", 32'(line_width), 32'd320);
    repeat (600) strobe(rnd8(), 4'b0000);
    strobe(rnd8(), 4'b0010);
    chk("lw_sat", 32'(line_width), 32'd511);
    strobe(rnd8(), 4'b0000);

    // frame lengths around the PAL threshold
    frame(3, 1'b0);
    frame(262, 1'b0);
    chk("lc_262", 32'({line_count, pal_detect}),
        32'({9'd262, 1'b0}));
    frame(312, 1'b0);
    chk("lc_312", 32'({line_count, pal_detect}),
        32'({9'd312, 1'b1}));
    frame(286, 1'b1);
    chk("lc_287", 32'({line_count, pal_detect}),
        32'({9'd287, 1'b0}));
    frame(287, 1'b1);
    chk("lc_288", 32'({line_count, pal_detect}),
        32'({9'd288, 1'b1}));
    frame(520, 1'b0);
    chk("lc_sat", 32'({line_count, pal_detect}),
        32'({9'd511, 1'b1}));

    // ce_in idle: everything frozen
    repeat (25) @(posedge clk_sys);
    #1;
    chk("frz_rgb", 32'({r, g, b}), 32'(exp_rgb));
    chk("frz_fl", 32'({hsync, vsync, hblank, vblank}),
        32'(exp_fl));
    chk("frz_meas",
        32'({line_width, line_count, pal_detect}),
        32'({exp_lw, exp_lc, exp_pd}));

    // reset mid-frame with strobes running
    frame(10, 1'b0);
    strobe(rnd8(), 4'b1000);
    strobe(8'h1F, 4'b0000);
    @(negedge clk_sys);
    reset = 1'b1; ce_in = 1'b1; yc = rnd8();
    @(posedge clk_sys); #1;
    chk("rst_out",
        32'({r, g, b, hsync, vsync, hblank,
             vblank, ce_pix}), 32'd0);
    chk("rst_meas",
        32'({line_width, line_count, pal_detect}),
        32'd0);
    @(negedge clk_sys);
    reset = 1'b0; ce_in = 1'b0;
    model_reset();

    // palette survives reset
    strobe(8'h1F, 4'b0000);
    strobe(8'h40, 4'b0000);
    strobe(rnd8(), 4'b0000);
    chk("keep_1F", 32'({r, g, b}), 32'h123456);
    strobe(rnd8(), 4'b0000);
    chk("keep_40", 32'({r, g, b}), 32'hABCDEF);
    repeat (40) strobe(rnd8(), 4'(($urandom % 16)));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
